// File: rtl/instruction_fetch_unit.sv
// Dual-issue fetch front end: reads two sequential words per cycle from a combinational ROM
// into a circular queue and presents the two oldest entries to decode.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH_IM = 8,
  parameter int INSTR_WIDTH   = 32,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic [ADDR_WIDTH_IM-1:0]         imem_address_1,
  output logic [ADDR_WIDTH_IM-1:0]         imem_address_2,
  input  logic [INSTR_WIDTH-1:0]           imem_read_data_1,
  input  logic [INSTR_WIDTH-1:0]           imem_read_data_2,
  input  logic                             redirect_valid,
  input  logic [ADDR_WIDTH_IM-1:0]         redirect_address,
  input  logic [1:0]                       decode_take,
  output logic                             instr_valid_1,
  output logic [INSTR_WIDTH-1:0]           instr_1,
  output logic [ADDR_WIDTH_IM-1:0]         instr_pc_1,
  output logic                             instr_valid_2,
  output logic [INSTR_WIDTH-1:0]           instr_2,
  output logic [ADDR_WIDTH_IM-1:0]         instr_pc_2,
  output logic [$clog2(QUEUE_DEPTH):0]     queue_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH_IM-1:0] pc;
  logic [ADDR_WIDTH_IM-1:0] pc_plus1;
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [PTR_W-1:0]         head_plus1;
  logic [PTR_W-1:0]         tail_plus1;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         take_req;
  logic [CNT_W-1:0]         take;
  logic                     enq;

  logic [INSTR_WIDTH-1:0]   q_instr [QUEUE_DEPTH];
  logic [ADDR_WIDTH_IM-1:0] q_pc    [QUEUE_DEPTH];

  assign pc_plus1   = pc + ADDR_WIDTH_IM'(1);
  assign head_plus1 = head + PTR_W'(1);
  assign tail_plus1 = tail + PTR_W'(1);

  assign imem_address_1 = pc;
  assign imem_address_2 = pc_plus1;

  // Fetch looks only at current occupancy; space freed by decode this cycle is used next cycle.
  assign enq = !redirect_valid && (count <= CNT_W'(QUEUE_DEPTH - 2));

  always_comb begin
    take_req = '0;
    case (decode_take)
      2'd0:    take_req = '0;
      2'd1:    take_req = CNT_W'(1);
      default: take_req = CNT_W'(2);
    endcase
    take = (take_req > count) ? count : take_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_address;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_W'(2);
        pc   <= pc + ADDR_WIDTH_IM'(2);
      end
      head  <= head + take[PTR_W-1:0];
      count <= count + (enq ? CNT_W'(2) : CNT_W'(0)) - take;
    end
  end

  // Storage needs no reset: entries beyond count are never presented.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      q_instr[tail]       <= imem_read_data_1;
      q_pc[tail]          <= pc;
      q_instr[tail_plus1] <= imem_read_data_2;
      q_pc[tail_plus1]    <= pc_plus1;
    end
  end

  assign instr_valid_1 = (count != '0);
  assign instr_valid_2 = (count >= CNT_W'(2));
  assign instr_1       = instr_valid_1 ? q_instr[head]       : '0;
  assign instr_pc_1    = instr_valid_1 ? q_pc[head]          : '0;
  assign instr_2       = instr_valid_2 ? q_instr[head_plus1] : '0;
  assign instr_pc_2    = instr_valid_2 ? q_pc[head_plus1]    : '0;
  assign queue_count   = count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: ROM[i]=i, directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_instruction_fetch_unit;

  localparam int AW = 8;
  localparam int IW = 32;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_address_1, imem_address_2;
  logic [IW-1:0] imem_read_data_1, imem_read_data_2;
  logic          redirect_valid;
  logic [AW-1:0] redirect_address;
  logic [1:0]    decode_take;
  logic          instr_valid_1, instr_valid_2;
  logic [IW-1:0] instr_1, instr_2;
  logic [AW-1:0] instr_pc_1, instr_pc_2;
  logic [2:0]    queue_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign imem_read_data_1 = IW'(imem_address_1);
  assign imem_read_data_2 = IW'(imem_address_2);

  instruction_fetch_unit #(.ADDR_WIDTH_IM(AW), .INSTR_WIDTH(IW), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .imem_address_1(imem_address_1), .imem_address_2(imem_address_2),
    .imem_read_data_1(imem_read_data_1), .imem_read_data_2(imem_read_data_2),
    .redirect_valid(redirect_valid), .redirect_address(redirect_address),
    .decode_take(decode_take),
    .instr_valid_1(instr_valid_1), .instr_1(instr_1), .instr_pc_1(instr_pc_1),
    .instr_valid_2(instr_valid_2), .instr_2(instr_2), .instr_pc_2(instr_pc_2),
    .queue_count(queue_count)
  );

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t        mq[$];
  logic [AW-1:0] mpc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: ROM word at address a is a itself; PC arithmetic is mod 256.
  task automatic model_update(input logic rst, input logic rv, input logic [AW-1:0] ra,
                              input logic [1:0] dt);
    int n;
    bit fetch;
    if (rst) begin
      mq.delete();
      mpc = '0;
    end else if (rv) begin
      mq.delete();
      mpc = ra;
    end else begin
      fetch = (QD - mq.size()) >= 2;
      n = (dt == 2'd3) ? 2 : int'(dt);
      if (n > mq.size()) n = mq.size();
      repeat (n) void'(mq.pop_front());
      if (fetch) begin
        mq.push_back('{instr: IW'(mpc), pc: mpc});
        mq.push_back('{instr: IW'(AW'(mpc + 1)), pc: AW'(mpc + 1)});
        mpc = AW'(mpc + 2);
      end
    end
  endtask

  task automatic check_all();
    bit v1, v2;
    v1 = mq.size() >= 1;
    v2 = mq.size() >= 2;
    check("imem_address_1", 32'(imem_address_1), 32'(mpc));
    check("imem_address_2", 32'(imem_address_2), 32'(AW'(mpc + 1)));
    check("queue_count", 32'(queue_count), mq.size());
    check("instr_valid_1", 32'(instr_valid_1), 32'(v1));
    check("instr_valid_2", 32'(instr_valid_2), 32'(v2));
    check("instr_1", instr_1, v1 ? mq[0].instr : '0);
    check("instr_pc_1", 32'(instr_pc_1), v1 ? 32'(mq[0].pc) : 32'd0);
    check("instr_2", instr_2, v2 ? mq[1].instr : '0);
    check("instr_pc_2", 32'(instr_pc_2), v2 ? 32'(mq[1].pc) : 32'd0);
  endtask

  task automatic step(input logic rst, input logic rv, input logic [AW-1:0] ra,
                      input logic [1:0] dt);
    @(negedge clk);
    reset = rst;
    redirect_valid = rv;
    redirect_address = ra;
    decode_take = dt;
    @(posedge clk);
    model_update(rst, rv, ra, dt);
    #1;
    check_all();
  endtask

  initial begin
    logic [AW-1:0] prev_pc;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_address = '0;
    decode_take = 2'd0;

    // Reset held two cycles
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    check("rst_addr1", 32'(imem_address_1), 32'd0);
    check("rst_addr2", 32'(imem_address_2), 32'd1);
    check("rst_valid1", 32'(instr_valid_1), 32'd0);

    // First fetch one cycle after release
    step(0, 0, 8'h00, 0);
    check("first_instr_2", instr_2, 32'd1);
    check("first_pc_2", 32'(instr_pc_2), 32'd1);
    check("first_count", 32'(queue_count), 32'd2);

    // Fill and hold
    step(0, 0, 8'h00, 0);
    check("fill_count", 32'(queue_count), 32'd4);
    step(0, 0, 8'h00, 0);
    check("full_count", 32'(queue_count), 32'd4);
    check("full_pc_hold", 32'(imem_address_1), 32'd4);

    // Streaming at two per cycle
    prev_pc = instr_pc_1;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 8'h00, 2);
      check("stream_pc_step", 32'(instr_pc_1), 32'(AW'(prev_pc + 2)));
      check("stream_count_min", 32'(queue_count >= 3'd2), 32'd1);
      prev_pc = instr_pc_1;
    end

    // Redirect while full
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h10, 2);
    check("redir_count", 32'(queue_count), 32'd0);
    check("redir_addr1", 32'(imem_address_1), 32'h10);
    check("redir_addr2", 32'(imem_address_2), 32'h11);
    step(0, 0, 8'h00, 0);
    check("redir_pc_1", 32'(instr_pc_1), 32'h10);
    check("redir_pc_2", 32'(instr_pc_2), 32'h11);

    // PC wrap
    step(0, 1, 8'hFF, 0);
    check("wrap_addr2", 32'(imem_address_2), 32'h00);
    step(0, 0, 8'h00, 0);
    check("wrap_pc_1", 32'(instr_pc_1), 32'hFF);
    check("wrap_pc_2", 32'(instr_pc_2), 32'h00);
    check("wrap_instr_2", instr_2, 32'h0);

    // take=2 with a single queued entry
    step(0, 1, 8'h20, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    check("odd_count3", 32'(queue_count), 32'd3);
    step(0, 0, 8'h00, 2);
    check("odd_count1", 32'(queue_count), 32'd1);
    step(0, 0, 8'h00, 2);
    check("take_clamped_count", 32'(queue_count), 32'd2);
    check("take_clamped_pc_1", 32'(instr_pc_1), 32'h24);

    // Reset together with redirect mid-stream
    step(0, 0, 8'h00, 0);
    step(1, 1, 8'h40, 2);
    check("rst_redir_pc", 32'(imem_address_1), 32'd0);
    check("rst_redir_count", 32'(queue_count), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) == 0),
           AW'($urandom), 2'($urandom_range(3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
